ov7670_capture_param: RTL

- Parametrised camera-capture front end for OV7670-class sensors on the pixel clock domain.
- Assembles sensor bytes into grayscale (Y), RGB565 or raw-byte pixels and emits frame-buffer write strobes with linear addresses.
- Adds per-line column clipping, address saturation, an overflow flag and frame-done signalling.
- Sits between the sensor pins and the dual-port frame-buffer BRAM; its output feeds the corner-detector datapath.

---
 rtl/ov7670_capture_param.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ov7670_capture_param.sv
// ============================================================================
// ov7670_capture_param : OV7670 byte-to-pixel capture with clipping/overflow.
// Optional decimation enabled by defining OV7670_CAPTURE_DECIM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ov7670_capture_param #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17,
  parameter int Y_FIRST  = 0
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic [1:0]        mode,
`ifdef OV7670_CAPTURE_DECIM_EN
  input  logic              decim,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic              overflow
);

  localparam int COL_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0]  COL_MAX    = COL_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] LINE_MAX   = LINE_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] FULL_LIMIT = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [ADDR_W-1:0] DEC_LIMIT  = ADDR_W'((H_ACTIVE / 2) * (V_ACTIVE / 2));

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dout_q, dout_d;
  logic              we_q, we_d;
  logic              fd_q, fd_d;
  logic              ovf_q, ovf_d;
  logic              phase_q, phase_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        byte_q, byte_d;
  logic              href_q, vsync_q;
  logic              wrote_q, wrote_d;
  logic              armed_q, armed_d;
  logic              w_decim;
  logic              w_decim_d;

`ifdef OV7670_CAPTURE_DECIM_EN
  logic decim_q;
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)        decim_q <= 1'b0;
    else if (vsync) decim_q <= decim;
  end
  assign w_decim   = decim_q;
  assign w_decim_d = decim;
`else
  assign w_decim   = 1'b0;
  assign w_decim_d = 1'b0;
`endif

  logic              w_rgb, w_raw, w_complete, w_keep, w_sat;
  logic [ADDR_W-1:0] w_addr_eff, w_limit;
  logic [15:0]       w_pix;

  assign w_rgb      = (mode_q == 2'd1);
  assign w_raw      = (mode_q == 2'd2);
  assign w_complete = w_raw | phase_q;
  // Pending post-write increment must be visible to back-to-back raw pixels.
  assign w_addr_eff = we_q ? addr_q + 1'b1 : addr_q;
  assign w_limit    = w_decim ? DEC_LIMIT : FULL_LIMIT;
  assign w_sat      = (w_addr_eff == w_limit);
  assign w_keep     = ~w_decim | (~col_q[0] & ~line_q[0]);

  always_comb begin
    w_pix = {8'h00, d};
    if (w_rgb)                      w_pix = {byte_q, d};
    else if (!w_raw && Y_FIRST != 0) w_pix = {8'h00, byte_q};
  end

  always_comb begin
    addr_d  = w_addr_eff;
    dout_d  = dout_q;
    we_d    = 1'b0;
    fd_d    = vsync & ~vsync_q & wrote_q;
    ovf_d   = ovf_q;
    phase_d = phase_q;
    col_d   = col_q;
    line_d  = line_q;
    mode_d  = mode_q;
    byte_d  = byte_q;
    wrote_d = wrote_q;
    armed_d = armed_q;
    if (vsync) begin
      mode_d  = mode;
      addr_d  = '0;
      phase_d = 1'b0;
      col_d   = '0;
      line_d  = '0;
      ovf_d   = 1'b0;
      wrote_d = 1'b0;
      armed_d = 1'b1;
    end else if (href) begin
      byte_d  = d;
      phase_d = ~phase_q;
      if (w_complete && armed_q) begin
        if (col_q != COL_MAX) col_d = col_q + 1'b1;
        if (col_q >= COL_MAX || line_q >= LINE_MAX) begin
          ovf_d = 1'b1;
        end else if (w_keep) begin
          if (w_sat) begin
            ovf_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            dout_d  = w_pix;
            wrote_d = 1'b1;
          end
        end
      end
    end else begin
      // A line boundary re-arms capture after a reset released mid-line.
      phase_d = 1'b0;
      armed_d = 1'b1;
      if (href_q && armed_q) begin
        col_d = '0;
        if (line_q != LINE_MAX) line_d = line_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      dout_q  <= '0;
      we_q    <= 1'b0;
      fd_q    <= 1'b0;
      ovf_q   <= 1'b0;
      phase_q <= 1'b0;
      col_q   <= '0;
      line_q  <= '0;
      mode_q  <= 2'd0;
      byte_q  <= 8'h00;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      wrote_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      fd_q    <= fd_d;
      ovf_q   <= ovf_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      line_q  <= line_d;
      mode_q  <= mode_d;
      byte_q  <= byte_d;
      href_q  <= href;
      vsync_q <= vsync;
      wrote_q <= wrote_d;
      armed_q <= armed_d;
    end
  end

  logic w_unused;
  assign w_unused = w_decim_d;

  assign addr       = addr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign frame_done = fd_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire
